// File: rtl/sw_event_pkg.sv
// Shared definitions for the switch event conditioner and the downstream
// coin/credit state machine that consumes its command codes.
package sw_event_pkg;

    localparam int N_SW = 5;

    localparam logic [N_SW-1:0] CMD_4   = 5'b00001;
    localparam logic [N_SW-1:0] CMD_8   = 5'b00010;
    localparam logic [N_SW-1:0] CMD_12  = 5'b00100;
    localparam logic [N_SW-1:0] CMD_SUB = 5'b01000;
    localparam logic [N_SW-1:0] CMD_RST = 5'b10000;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic is_onehot(input logic [N_SW-1:0] v);
        return (v != '0) && ((v & (v - N_SW'(1))) == '0);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a stable-run debounce counter.
// The debounced level only moves after DEBOUNCE_CYCLES consecutive mismatching cycles.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic sw_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            sw_db   <= 1'b0;
        end else begin
            sync_p0 <= sw;
            sync_p1 <= sync_p0;
            // A single matching cycle discards the whole run collected so far.
            if (sync_p1 == sw_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_db <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_event_conditioner.sv
// Turns debounced board switches into one-cycle, one-hot command pulses,
// issuing at most one decision per press and waiting for a full release.
module sw_event_conditioner
    import sw_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic [N_SW-1:0] SW,
    output logic            evt_valid,
    output logic [N_SW-1:0] evt_code,
    output logic            evt_err,
    output logic            busy,
    output logic [N_SW-1:0] sw_db
);

    state_t state;

    for (genvar i = 0; i < N_SW; i++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (CLOCK_50),
            .rst_n(RESET_N),
            .sw   (SW[i]),
            .sw_db(sw_db[i])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_err   <= 1'b0;
            busy      <= 1'b0;
            evt_code  <= '0;
        end else begin
            evt_valid <= 1'b0;
            evt_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sw_db != '0) begin
                        state <= HOLD;
                        busy  <= 1'b1;
                        // The reset switch wins over any other bits pressed with it.
                        if (sw_db[N_SW-1]) begin
                            evt_valid <= 1'b1;
                            evt_code  <= CMD_RST;
                        end else if (is_onehot(sw_db)) begin
                            evt_valid <= 1'b1;
                            evt_code  <= sw_db;
                        end else begin
                            evt_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (sw_db == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_event_conditioner.sv
// Bench for sw_event_conditioner with DEBOUNCE_CYCLES=4: directed scenarios
// with literal expectations, then random switch activity against a rule-level model.
module tb_sw_event_conditioner;

    localparam int D = 4;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [4:0] SW;
    logic       evt_valid;
    logic [4:0] evt_code;
    logic       evt_err;
    logic       busy;
    logic [4:0] sw_db;

    sw_event_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SW       (SW),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_err  (evt_err),
        .busy     (busy),
        .sw_db    (sw_db)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Rule-level model: switch samples reach the debouncer two edges late,
    // a level is accepted after D consecutive disagreeing samples, and the
    // arbiter decides once per press, then waits for everything to drop.
    logic       m_valid, m_err, m_busy;
    logic [4:0] m_code, m_db;
    int         m_run [5];
    logic [4:0] seen_q[$];

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        logic [4:0] db_n, code_n, seen;
        logic       v_n, e_n, b_n;
        int         r [5];
        if (!RESET_N) begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_busy  <= 1'b0;
            m_code  <= 5'b0;
            m_db    <= 5'b0;
            m_run   <= '{0, 0, 0, 0, 0};
            seen_q  = {5'b0, 5'b0};
        end else begin
            v_n = 1'b0; e_n = 1'b0; b_n = m_busy; code_n = m_code; db_n = m_db; r = m_run;
            if (!m_busy && m_db != 5'b0) begin
                b_n = 1'b1;
                if (m_db[4]) begin
                    v_n = 1'b1; code_n = 5'b10000;
                end else if ($countones(m_db) == 1) begin
                    v_n = 1'b1; code_n = m_db;
                end else begin
                    e_n = 1'b1;
                end
            end else if (m_busy && m_db == 5'b0) begin
                b_n = 1'b0;
            end
            seen = seen_q.pop_front();
            seen_q.push_back(SW);
            for (int i = 0; i < 5; i++) begin
                if (seen[i] != m_db[i]) begin
                    r[i] = r[i] + 1;
                    if (r[i] == D) begin
                        db_n[i] = seen[i];
                        r[i] = 0;
                    end
                end else begin
                    r[i] = 0;
                end
            end
            m_valid <= v_n; m_err <= e_n; m_busy <= b_n; m_code <= code_n;
            m_db <= db_n; m_run <= r;
        end
    end

    int n_chk, n_fail;
    int vcount, ecount;
    bit chk_en;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (busy == 1'b0 && sw_db == 5'b0) break;
            wait_edge();
        end
        check("idle_reached", 32'({busy, sw_db}), 32'd0);
    endtask

    // Press a pattern and require exactly one decision 7 edges later.
    task automatic press(input logic [4:0] pat, input logic exp_v, input logic exp_e,
                         input logic [4:0] exp_code);
        SW = pat;
        for (int k = 1; k <= D + 3; k++) begin
            wait_edge();
            if (k < D + 3) check("no_early_event", 32'({evt_valid, evt_err}), 32'd0);
        end
        check("press_valid", 32'(evt_valid), 32'(exp_v));
        check("press_err", 32'(evt_err), 32'(exp_e));
        check("press_code", 32'(evt_code), 32'(exp_code));
        check("press_busy", 32'(busy), 32'd1);
        wait_edge();
        check("pulse_one_cycle", 32'({evt_valid, evt_err}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e0;
        RESET_N = 1'b0;
        SW      = 5'b0;
        chk_en  = 1'b0;
        n_chk   = 0;
        n_fail  = 0;
        vcount  = 0;
        ecount  = 0;

        fork
            forever begin
                @(negedge CLOCK_50);
                vcount += int'(evt_valid);
                ecount += int'(evt_err);
                if (chk_en) begin
                    check("model_cmp", 32'({evt_valid, evt_err, busy, evt_code, sw_db}),
                          32'({m_valid, m_err, m_busy, m_code, m_db}));
                    check("valid_err_exclusive", 32'(evt_valid & evt_err), 32'd0);
                end
            end
        join_none

        // Reset and idle
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_outputs", 32'({evt_valid, evt_err, busy, evt_code, sw_db}), 32'd0);
        RESET_N = 1'b1;
        chk_en  = 1'b1;
        c0 = vcount; e0 = ecount;
        repeat (20) wait_edge();
        check("idle_no_events", 32'((vcount - c0) + (ecount - e0)), 32'd0);

        // Clean press and release
        press(5'b00001, 1'b1, 1'b0, 5'b00001);
        SW = 5'b0;
        for (int k = 1; k <= D + 3; k++) begin
            wait_edge();
            if (k == D + 1) check("release_busy_held", 32'(busy), 32'd1);
        end
        check("release_busy_clear", 32'(busy), 32'd0);

        // Bounce rejection on SW[1]
        c0 = vcount;
        for (int b = 0; b < 3; b++) begin
            SW = 5'b00010; wait_edge(); wait_edge();
            SW = 5'b00000; wait_edge();
        end
        press(5'b00010, 1'b1, 1'b0, 5'b00010);
        repeat (4) wait_edge();
        check("bounce_single_event", 32'(vcount - c0), 32'd1);
        SW = 5'b0;
        wait_idle();

        // Illegal chord, then a legal press
        c0 = vcount;
        press(5'b00110, 1'b0, 1'b1, 5'b00010);
        check("chord_no_valid", 32'(vcount - c0), 32'd0);
        SW = 5'b0;
        wait_idle();
        press(5'b01000, 1'b1, 1'b0, 5'b01000);
        SW = 5'b0;
        wait_idle();

        // Reset priority, then extra switch during HOLD is ignored
        press(5'b10100, 1'b1, 1'b0, 5'b10000);
        c0 = vcount; e0 = ecount;
        SW = 5'b10101;
        repeat (12) wait_edge();
        check("hold_ignores_valid", 32'(vcount - c0), 32'd0);
        check("hold_ignores_err", 32'(ecount - e0), 32'd0);
        SW = 5'b0;
        wait_idle();

        // Asynchronous reset in the middle of a debounce
        SW = 5'b00100;
        repeat (4) wait_edge();
        #1 RESET_N = 1'b0;
        #1;
        check("async_reset_clear", 32'({evt_valid, evt_err, busy, evt_code, sw_db}), 32'd0);
        repeat (2) @(posedge CLOCK_50);
        #1 RESET_N = 1'b1;
        c0 = vcount;
        for (int k = 1; k <= D + 3; k++) begin
            wait_edge();
            if (k < D + 3) check("post_reset_quiet", 32'(evt_valid), 32'd0);
        end
        check("post_reset_valid", 32'(evt_valid), 32'd1);
        check("post_reset_code", 32'(evt_code), 32'b00100);
        repeat (6) wait_edge();
        check("post_reset_single", 32'(vcount - c0), 32'd1);
        SW = 5'b0;
        wait_idle();

        // Random activity against the model
        for (int n = 0; n < 300; n++) begin
            int sel, hold;
            logic [4:0] pat;
            sel  = int'($urandom_range(0, 19));
            hold = int'($urandom_range(1, 12));
            pat  = 5'($urandom);
            if (sel < 7) begin
                SW = 5'b0;
                repeat (hold) wait_edge();
            end else if (sel < 12) begin
                SW = 5'b1 << $urandom_range(0, 4);
                repeat (hold) wait_edge();
            end else if (sel < 15) begin
                SW = pat;
                repeat (hold) wait_edge();
            end else if (sel < 19) begin
                for (int k = 0; k < hold; k++) begin
                    SW = ($urandom_range(0, 1) == 1) ? pat : 5'b0;
                    wait_edge();
                end
            end else begin
                RESET_N = 1'b0;
                repeat (int'($urandom_range(1, 3))) wait_edge();
                RESET_N = 1'b1;
            end
        end
        SW = 5'b0;
        repeat (20) wait_edge();
        check("final_idle", 32'({busy, sw_db}), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
